sparse_pair_producer: RTL and testbench
=======================================

# sparse_pair_producer

Producer end of the sparse multiply-accumulate pair buffer. It merge-joins two index-sorted sparse operand streams, A and B. For every index present in both streams it writes one `{valid, a, b}` pair into a free slot of an N-entry pair buffer. The MAC consumer reads valid slots and returns per-slot consume strobes, which free the slots.

## Interface

Parameters:
- `DATA_SIZE`, 16: operand value width
- `IDX_SIZE`, 8: sparse index width
- `N`, 4: pair buffer slots

Ports:
- `clk` in 1: clock
- `rst_n` in 1: reset. One clock; reset is asynchronous and active-low.
- `start` in 1: one-cycle pulse; begins a job. Ignored unless state is IDLE.
- `a_valid` in 1: stream A element valid
- `a_ready` out 1: stream A element accepted this cycle
- `a_idx` in IDX_SIZE: stream A index
- `a_data` in DATA_SIZE: stream A value
- `a_last` in 1: final element of stream A
- `b_valid`, `b_ready`, `b_idx`, `b_data`, `b_last`: same as A, for stream B
- `buffer` out `pair[N-1:0]`: pair slots; fields `valid`, `a`, `b`
- `consume` in N: bit i clears `buffer[i].valid`
- `pair_count` out IDX_SIZE+1: pairs emitted since the last `start`
- `busy` out 1: state is not IDLE
- `done` out 1: one-cycle pulse at job completion

## Operation

- Stream rules:
  - Indices are strictly increasing within each stream. This is not checked.
  - Each stream carries at least one element; `last` marks the end.
  - A handshake occurs when valid and ready are both high.
- States: IDLE, MERGE, DRAIN_A, DRAIN_B, FLUSH.
- IDLE:
  - `start` → MERGE.
  - On the same edge, `pair_count` clears to 0.
- MERGE acts only when `a_valid && b_valid`:
  - `a_idx < b_idx`: pop A.
  - `a_idx > b_idx`: pop B.
  - Equal, with a free slot: write `{1, a_data, b_data}` into the lowest-numbered free slot, pop both, increment `pair_count`.
  - Equal, no free slot: stall; `a_ready = b_ready = 0`.
  - If only one stream is valid: no pop.
- Stream termination, evaluated on popped elements only:
  - Popped A with `a_last`, B not yet ended → DRAIN_B.
  - Popped B with `b_last`, A not yet ended → DRAIN_A.
  - Both end on the same edge → FLUSH.
- DRAIN_X:
  - `x_ready = 1`; the other stream's ready is 0.
  - Elements are discarded; no pairs are written.
  - Popping X with `x_last` → FLUSH.
- FLUSH:
  - Waits until all `buffer[i].valid` are 0.
  - On that edge: `done` pulses, then → IDLE.
- Slot freedom:
  - A slot is free when its registered `valid` is 0.
  - A slot being consumed in the current cycle is not free until the next cycle, so writes and consumes never target the same slot on the same edge.
- Consume behaviour:
  - `consume[i]` on an invalid slot is ignored.
  - Consume clears only `valid`; the `a`/`b` fields hold their last value.
- Ready signals are combinational from state, stream valids, index compare and slot freedom. They are 0 in IDLE and FLUSH.

## Timing

- Reset values:
  - All `buffer[i]` zero
  - `pair_count` 0
  - `done` 0
  - `busy` 0
  - `a_ready`, `b_ready` 0
  - state IDLE
- Reset mid-job aborts immediately; partial pairs are discarded.
- Latency:
  - A matching handshake on edge t makes the pair visible in `buffer` after edge t.
  - Consume on edge t clears `valid` after edge t.
- `busy` rises the cycle after `start`.
- `done` is registered and high for exactly one cycle. `busy` falls in that same cycle.
- Throughput: at most one pop per stream per cycle, and at most one pair written per cycle.
- Once both streams have ended, no further readies are asserted until the next `start`.

## Structure

- `sparse_pkg` holds:
  - `pair` typedef (`valid`, `a`, `b`)
  - new `sparse_elem` typedef (`idx`, `data`, `last`)
  - state enum
- Sub-module `sparse_slot_alloc`: N-bit free mask in; `found` and lowest-free-index out. Purely combinational.
- The top level holds the FSM, compare/pop logic, slot registers and the counter.

## Test plan

- **Basic intersection.** A idx {1,3,5,7} (last on 7), B {3,4,7} (last on 7), consume each slot one cycle after it is written → pairs (A3,B3) in slot 0 and (A7,B7) in slot 0; `pair_count` = 2; `done` pulses once; `busy` ends 0.
- **Full buffer.** N=4, both streams idx 0..5, no consume → slots 0-3 valid, both readies 0 (stall). Pulse `consume[2]` → next cycle idx 4 is written to slot 2. Continue consuming → `pair_count` = 6.
- **Early end and drain.** A {2} (last), B {1,2,9,10} (last on 10) → one pair; DRAIN_B pops 9 and 10 with no writes; FLUSH; `done` follows consume of slot 0.
- **Simultaneous consume and match.** Buffer full, `consume[0]` on the same cycle as a matching head → no write that cycle; the write lands in slot 0 on the next cycle.
- **Backpressure.** A {1,3,5,7}, B {3,4,7} with random valid gaps on each stream → same pairs as the basic case; no pop while either valid is 0 in MERGE.
- **Reset mid-job.** `rst_n` low while in MERGE with two valid slots → all slots 0, `busy` 0, readies 0 asynchronously. A new `start` runs the basic case correctly.

Source files
------------

// File: rtl/sparse_pkg.sv
// Shared types for the sparse MAC pair producer: buffer slot, stream element
// and producer FSM states.
package sparse_pkg;

    localparam int DATA_W = 16;
    localparam int IDX_W  = 8;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } pair;

    typedef struct packed {
        logic [IDX_W-1:0]  idx;
        logic [DATA_W-1:0] data;
        logic              last;
    } sparse_elem;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MERGE,
        ST_DRAIN_A,
        ST_DRAIN_B,
        ST_FLUSH
    } state_t;

endpackage

// File: rtl/sparse_slot_alloc.sv
// Lowest-free-slot finder for the pair buffer; purely combinational.
module sparse_slot_alloc #(
    parameter int N      = 4,
    parameter int SLOT_W = 2
) (
    input  logic [N-1:0]      free_mask,
    output logic              found,
    output logic [SLOT_W-1:0] idx
);

    always_comb begin
        found = |free_mask;
        idx   = '0;
        // Scan downwards so the lowest set bit is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (free_mask[i]) begin
                idx = SLOT_W'(i);
            end
        end
    end

endmodule

// File: rtl/sparse_pair_producer.sv
// Merge-joins two index-sorted sparse streams and deposits matching
// {a, b} operand pairs into free slots of the MAC pair buffer.
module sparse_pair_producer
    import sparse_pkg::*;
#(
    parameter int DATA_SIZE = DATA_W,
    parameter int IDX_SIZE  = IDX_W,
    parameter int N         = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic [IDX_SIZE-1:0]   a_idx,
    input  logic [DATA_SIZE-1:0]  a_data,
    input  logic                  a_last,
    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic [IDX_SIZE-1:0]   b_idx,
    input  logic [DATA_SIZE-1:0]  b_data,
    input  logic                  b_last,
    output pair   [N-1:0]         buffer,
    input  logic [N-1:0]          consume,
    output logic [IDX_SIZE:0]     pair_count,
    output logic                  busy,
    output logic                  done
);

    localparam int SLOT_W = (N > 1) ? $clog2(N) : 1;

    state_t            state, state_next;
    sparse_elem        a_head, b_head;
    logic [N-1:0]      free_mask;
    logic              found;
    logic [SLOT_W-1:0] free_idx;
    logic              write_en;
    logic              done_next;
    logic              all_free;

    assign a_head = '{idx: a_idx, data: a_data, last: a_last};
    assign b_head = '{idx: b_idx, data: b_data, last: b_last};

    // Freedom comes from the registered valid only, so a slot consumed this
    // cycle cannot be rewritten on the same edge.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            free_mask[i] = ~buffer[i].valid;
        end
    end

    assign all_free = &free_mask;
    assign busy     = (state != ST_IDLE);

    sparse_slot_alloc #(
        .N      (N),
        .SLOT_W (SLOT_W)
    ) u_alloc (
        .free_mask (free_mask),
        .found     (found),
        .idx       (free_idx)
    );

    always_comb begin
        state_next = state;
        a_ready    = 1'b0;
        b_ready    = 1'b0;
        write_en   = 1'b0;
        done_next  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_MERGE;
                end
            end
            ST_MERGE: begin
                if (a_valid && b_valid) begin
                    if (a_head.idx < b_head.idx) begin
                        a_ready = 1'b1;
                    end else if (a_head.idx > b_head.idx) begin
                        b_ready = 1'b1;
                    end else if (found) begin
                        a_ready  = 1'b1;
                        b_ready  = 1'b1;
                        write_en = 1'b1;
                    end
                end
                // Readies in MERGE imply the matching valid, so these are pops.
                if (a_ready && a_head.last && b_ready && b_head.last) begin
                    state_next = ST_FLUSH;
                end else if (a_ready && a_head.last) begin
                    state_next = ST_DRAIN_B;
                end else if (b_ready && b_head.last) begin
                    state_next = ST_DRAIN_A;
                end
            end
            ST_DRAIN_A: begin
                a_ready = 1'b1;
                if (a_valid && a_head.last) begin
                    state_next = ST_FLUSH;
                end
            end
            ST_DRAIN_B: begin
                b_ready = 1'b1;
                if (b_valid && b_head.last) begin
                    state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (all_free) begin
                    done_next  = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            done       <= 1'b0;
            pair_count <= '0;
        end else begin
            state <= state_next;
            done  <= done_next;
            if (state == ST_IDLE && start) begin
                pair_count <= '0;
            end else if (write_en) begin
                pair_count <= pair_count + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buffer <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (write_en && free_idx == SLOT_W'(i)) begin
                    buffer[i] <= '{valid: 1'b1, a: a_data, b: b_data};
                end else if (consume[i]) begin
                    buffer[i].valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_sparse_pair_producer.sv
// Bench for sparse_pair_producer: drives randomized stream gaps and consumer
// strobes, and checks pairs, slot choice and readies against a list model.
module tb_sparse_pair_producer;
    import sparse_pkg::*;

    localparam int DW = 16;
    localparam int IW = 8;
    localparam int N  = 4;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              a_valid, a_ready, a_last;
    logic [IW-1:0]     a_idx;
    logic [DW-1:0]     a_data;
    logic              b_valid, b_ready, b_last;
    logic [IW-1:0]     b_idx;
    logic [DW-1:0]     b_data;
    pair   [N-1:0]     buffer;
    logic [N-1:0]      consume;
    logic [IW:0]       pair_count;
    logic              busy;
    logic              done;

    int                a_list[$];
    int                b_list[$];
    logic [DW-1:0]     a_dat[$];
    logic [DW-1:0]     b_dat[$];
    logic [2*DW-1:0]   exp_q[$];
    int                checks = 0;
    int                errors = 0;

    sparse_pair_producer #(
        .DATA_SIZE (DW),
        .IDX_SIZE  (IW),
        .N         (N)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a_valid    (a_valid),
        .a_ready    (a_ready),
        .a_idx      (a_idx),
        .a_data     (a_data),
        .a_last     (a_last),
        .b_valid    (b_valid),
        .b_ready    (b_ready),
        .b_idx      (b_idx),
        .b_data     (b_data),
        .b_last     (b_last),
        .buffer     (buffer),
        .consume    (consume),
        .pair_count (pair_count),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] vmask();
        logic [N-1:0] m;
        for (int i = 0; i < N; i++) m[i] = buffer[i].valid;
        return m;
    endfunction

    function automatic int lowest_free(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (!v[i]) return i;
        return -1;
    endfunction

    // Random payloads plus the intersection of the two index lists, in index order.
    task automatic prepare_job();
        a_dat.delete();
        b_dat.delete();
        exp_q.delete();
        foreach (a_list[i]) a_dat.push_back(DW'($urandom()));
        foreach (b_list[j]) b_dat.push_back(DW'($urandom()));
        foreach (a_list[i])
            foreach (b_list[j])
                if (a_list[i] == b_list[j]) exp_q.push_back({a_dat[i], b_dat[j]});
    endtask

    task automatic gen_lists(input int density);
        a_list.delete();
        b_list.delete();
        for (int k = 0; k < 32; k++) begin
            if ($urandom_range(99) < density) a_list.push_back(k);
            if ($urandom_range(99) < density) b_list.push_back(k);
        end
        if (a_list.size() == 0) a_list.push_back(int'($urandom_range(31)));
        if (b_list.size() == 0) b_list.push_back(int'($urandom_range(31)));
    endtask

    task automatic check_idle_quiet(input string tag);
        a_valid = 1'b1;
        b_valid = 1'b1;
        a_idx   = 8'd5;
        b_idx   = 8'd5;
        #2;
        check({tag, "_a_ready"}, a_ready, 0);
        check({tag, "_b_ready"}, b_ready, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    task automatic run_job(input int gap_pct, input int hold, input int first_slot,
                           input int cons_pct, input int abort_pairs);
        int           ai, bi, cyc, pairs_seen, exp_total, new_cnt, exp_slot;
        bit           a_end, b_end, a_pop, b_pop, finished, first_done;
        logic         ea, eb;
        logic [N-1:0] prev_v, cur_v;
        prepare_job();
        exp_total  = exp_q.size();
        ai = 0; bi = 0; cyc = 0; pairs_seen = 0;
        a_end = 0; b_end = 0; a_pop = 0; b_pop = 0; finished = 0; first_done = 0;
        @(negedge clk);
        a_valid = 1'b0; b_valid = 1'b0; consume = '0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("count_cleared", pair_count, 0);
        prev_v = vmask();
        while (!finished && cyc < 400) begin
            cyc++;
            cur_v   = vmask();
            new_cnt = 0;
            exp_slot = lowest_free(prev_v);
            for (int i = 0; i < N; i++) begin
                if (cur_v[i] && !prev_v[i]) begin
                    new_cnt++;
                    check("slot_lowest_free", i, exp_slot);
                    if (exp_q.size() == 0) check("unexpected_pair", 1, 0);
                    else check("pair_data", {buffer[i].a, buffer[i].b}, exp_q.pop_front());
                    pairs_seen++;
                end
            end
            if (new_cnt > 1) check("one_write_per_cycle", new_cnt, 1);
            check("pair_count", pair_count, pairs_seen);
            if (done) begin
                check("done_needs_empty", prev_v, 0);
                check("done_streams_ended", a_end && b_end, 1);
                check("busy_falls_with_done", busy, 0);
                finished = 1;
                break;
            end
            if (abort_pairs > 0 && pairs_seen >= abort_pairs) break;
            prev_v = cur_v;
            if (a_pop) begin ai++; a_valid = 1'b0; a_pop = 0; end
            if (b_pop) begin bi++; b_valid = 1'b0; b_pop = 0; end
            if (!a_valid && !a_end && ai < a_list.size() && $urandom_range(99) >= gap_pct) begin
                a_valid = 1'b1;
                a_idx   = IW'(a_list[ai]);
                a_data  = a_dat[ai];
                a_last  = (ai == a_list.size() - 1);
            end
            if (!b_valid && !b_end && bi < b_list.size() && $urandom_range(99) >= gap_pct) begin
                b_valid = 1'b1;
                b_idx   = IW'(b_list[bi]);
                b_data  = b_dat[bi];
                b_last  = (bi == b_list.size() - 1);
            end
            consume = '0;
            if (cyc > hold) begin
                if (first_slot >= 0 && !first_done) begin
                    if (cur_v[first_slot]) begin
                        consume[first_slot] = 1'b1;
                        first_done = 1;
                    end
                end else begin
                    for (int i = 0; i < N; i++) begin
                        if (cur_v[i] && $urandom_range(99) < cons_pct) consume[i] = 1'b1;
                        else if (!cur_v[i] && $urandom_range(99) < 10) consume[i] = 1'b1;
                    end
                end
            end
            #2;
            ea = 1'b0;
            eb = 1'b0;
            if (!(a_end && b_end)) begin
                if (a_end) eb = 1'b1;
                else if (b_end) ea = 1'b1;
                else if (a_valid && b_valid) begin
                    if (a_idx < b_idx) ea = 1'b1;
                    else if (a_idx > b_idx) eb = 1'b1;
                    else if (cur_v != '1) begin ea = 1'b1; eb = 1'b1; end
                end
            end
            check("a_ready", a_ready, ea);
            check("b_ready", b_ready, eb);
            a_pop = a_valid && a_ready;
            b_pop = b_valid && b_ready;
            if (a_pop && a_last) a_end = 1;
            if (b_pop && b_last) b_end = 1;
            @(negedge clk);
        end
        consume = '0;
        a_valid = 1'b0;
        b_valid = 1'b0;
        if (abort_pairs == 0) begin
            check("job_completed", finished, 1);
            check("pairs_missing", exp_q.size(), 0);
            check("final_pair_count", pair_count, exp_total);
            @(negedge clk);
            check_idle_quiet("after_done");
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; consume = '0;
        a_valid = 1'b0; a_idx = '0; a_data = '0; a_last = 1'b0;
        b_valid = 1'b0; b_idx = '0; b_data = '0; b_last = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_buffer_zero", buffer == '0, 1);
        check("reset_pair_count", pair_count, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_quiet("reset_idle");

        // Basic intersection with immediate consume
        a_list = '{1, 3, 5, 7};
        b_list = '{3, 4, 7};
        run_job(0, 0, -1, 100, 0);

        // Full buffer, then release slot 2 first
        a_list = '{0, 1, 2, 3, 4, 5};
        b_list = '{0, 1, 2, 3, 4, 5};
        run_job(0, 12, 2, 50, 0);

        // A ends early, B drains
        a_list = '{2};
        b_list = '{1, 2, 9, 10};
        run_job(0, 0, -1, 100, 0);

        // Full buffer, consume slot 0 while the head matches
        a_list = '{0, 1, 2, 3, 4, 5};
        b_list = '{0, 1, 2, 3, 4, 5};
        run_job(0, 12, 0, 100, 0);

        // Backpressure with random valid gaps
        a_list = '{1, 3, 5, 7};
        b_list = '{3, 4, 7};
        run_job(40, 0, -1, 60, 0);

        // Reset while in MERGE with two slots held
        a_list = '{1, 3, 5, 7, 9};
        b_list = '{1, 3, 8, 9};
        run_job(0, 100, -1, 0, 2);
        a_valid = 1'b1; b_valid = 1'b1; a_idx = 8'd1; b_idx = 8'd2;
        #1 rst_n = 1'b0;
        #1;
        check("midjob_reset_buffer", buffer == '0, 1);
        check("midjob_reset_busy", busy, 0);
        check("midjob_reset_a_ready", a_ready, 0);
        check("midjob_reset_b_ready", b_ready, 0);
        check("midjob_reset_count", pair_count, 0);
        a_valid = 1'b0; b_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        a_list = '{1, 3, 5, 7};
        b_list = '{3, 4, 7};
        run_job(0, 0, -1, 100, 0);

        // Random sparse lists
        for (int r = 0; r < 8; r++) begin
            gen_lists(40);
            run_job(30, int'($urandom_range(6)), -1, 50, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
